// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : E-stage MIPS multiply/divide unit holding the HI/LO registers,
//                with fixed multi-cycle busy timing for MULT(U)/DIV(U).
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hi_sel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_out
);
    localparam logic [2:0] c_OP_MULT  = 3'b001;
    localparam logic [2:0] c_OP_MULTU = 3'b010;
    localparam logic [2:0] c_OP_DIV   = 3'b011;
    localparam logic [2:0] c_OP_DIVU  = 3'b100;
    localparam logic [2:0] c_OP_MTHI  = 3'b101;
    localparam logic [2:0] c_OP_MTLO  = 3'b110;
    localparam logic [3:0] c_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_CNT  = 4'(DIV_CYCLES);

    logic        r_busy_q,   w_busy_d;
    logic        r_commit_q, w_commit_d;
    logic [3:0]  r_cnt_q,    w_cnt_d;
    logic [31:0] r_hi_q,     w_hi_d;
    logic [31:0] r_lo_q,     w_lo_d;
    logic [31:0] r_hi_t_q,   w_hi_t_d;
    logic [31:0] r_lo_t_q,   w_lo_t_d;

    logic        w_accept;
    logic        w_signed;
    logic        w_quot_neg;
    logic        w_rem_neg;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_product;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_uquot;
    logic [31:0] w_urem;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_accept = start && !r_busy_q && (md_op != 3'b000) && (md_op != 3'b111);
    assign w_signed = (md_op == c_OP_MULT) || (md_op == c_OP_DIV);

    // The low 64 bits of a product of sign-extended operands equal the signed product.
    assign w_mul_a   = w_signed ? {{32{A[31]}}, A} : {32'd0, A};
    assign w_mul_b   = w_signed ? {{32{B[31]}}, B} : {32'd0, B};
    assign w_product = w_mul_a * w_mul_b;

    // Signed division on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_abs_a    = (w_signed && A[31]) ? (32'd0 - A) : A;
    assign w_abs_b    = (w_signed && B[31]) ? (32'd0 - B) : B;
    assign w_uquot    = (B == 32'd0) ? 32'd0 : (w_abs_a / w_abs_b);
    assign w_urem     = (B == 32'd0) ? 32'd0 : (w_abs_a % w_abs_b);
    assign w_quot_neg = w_signed && (A[31] ^ B[31]);
    assign w_rem_neg  = w_signed && A[31];
    assign w_quot     = w_quot_neg ? (32'd0 - w_uquot) : w_uquot;
    assign w_rem      = w_rem_neg  ? (32'd0 - w_urem)  : w_urem;

    always_comb begin
        w_busy_d   = r_busy_q;
        w_commit_d = r_commit_q;
        w_cnt_d    = r_cnt_q;
        w_hi_d     = r_hi_q;
        w_lo_d     = r_lo_q;
        w_hi_t_d   = r_hi_t_q;
        w_lo_t_d   = r_lo_t_q;
        if (r_busy_q) begin
            w_cnt_d = r_cnt_q - 4'd1;
            if (r_cnt_q == 4'd1) begin
                w_busy_d = 1'b0;
                if (r_commit_q) begin
                    w_hi_d = r_hi_t_q;
                    w_lo_d = r_lo_t_q;
                end
            end
        end else if (w_accept) begin
            case (md_op)
                c_OP_MULT, c_OP_MULTU: begin
                    w_hi_t_d   = w_product[63:32];
                    w_lo_t_d   = w_product[31:0];
                    w_cnt_d    = c_MULT_CNT;
                    w_busy_d   = 1'b1;
                    w_commit_d = 1'b1;
                end
                c_OP_DIV, c_OP_DIVU: begin
                    w_hi_t_d   = w_rem;
                    w_lo_t_d   = w_quot;
                    w_cnt_d    = c_DIV_CNT;
                    w_busy_d   = 1'b1;
                    // A zero divisor still takes the full latency but leaves HI/LO alone.
                    w_commit_d = (B != 32'd0);
                end
                c_OP_MTHI: w_hi_d = A;
                c_OP_MTLO: w_lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy_q   <= 1'b0;
            r_commit_q <= 1'b0;
            r_cnt_q    <= 4'd0;
            r_hi_q     <= 32'd0;
            r_lo_q     <= 32'd0;
            r_hi_t_q   <= 32'd0;
            r_lo_t_q   <= 32'd0;
        end else begin
            r_busy_q   <= w_busy_d;
            r_commit_q <= w_commit_d;
            r_cnt_q    <= w_cnt_d;
            r_hi_q     <= w_hi_d;
            r_lo_q     <= w_lo_d;
            r_hi_t_q   <= w_hi_t_d;
            r_lo_t_q   <= w_lo_t_d;
        end
    end

    assign busy   = r_busy_q;
    assign HI     = r_hi_q;
    assign LO     = r_lo_q;
    assign md_out = hi_sel ? r_hi_q : r_lo_q;
endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit against an arithmetic
//                reference model of HI/LO and busy timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
    localparam int         MULT_N   = 5;
    localparam int         DIV_N    = 10;
    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_sel;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] md_out;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .A      (A),
        .B      (B),
        .hi_sel (hi_sel),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .md_out (md_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural result {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [31:0]     q;
        logic [31:0]     r;
        logic [63:0]     res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        res = 64'd0;
        case (op)
            OP_MULT:  res = sa * sb;
            OP_MULTU: res = ua * ub;
            OP_DIV: begin
                q   = 32'(sa / sb);
                r   = 32'(sa % sb);
                res = {r, q};
            end
            OP_DIVU: begin
                q   = a / b;
                r   = a % b;
                res = {r, q};
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'(1 + $urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, HI, m_hi);
        chk({tag, "_lo"}, LO, m_lo);
        hi_sel = 1'b1;
        #1;
        chk({tag, "_mdout_hi"}, md_out, m_hi);
        hi_sel = 1'b0;
        #1;
        chk({tag, "_mdout_lo"}, md_out, m_lo);
    endtask

    // Issue one op; optionally poke MTLO/MTHI at the first and last busy edges.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit intrude, input logic [31:0] intr_a);
        int          n;
        logic [63:0] r;
        logic [31:0] new_hi;
        logic [31:0] new_lo;
        n      = 0;
        new_hi = m_hi;
        new_lo = m_lo;
        case (op)
            OP_MULT, OP_MULTU: begin
                n = MULT_N;
                r = ref_md(op, a, b);
                new_hi = r[63:32];
                new_lo = r[31:0];
            end
            OP_DIV, OP_DIVU: begin
                n = DIV_N;
                if (b != 32'd0) begin
                    r = ref_md(op, a, b);
                    new_hi = r[63:32];
                    new_lo = r[31:0];
                end
            end
            OP_MTHI: new_hi = a;
            OP_MTLO: new_lo = a;
            default: ;
        endcase
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        step();
        start = 1'b0;
        md_op = OP_NONE;
        for (int k = 0; k < n; k++) begin
            chk("busy_high", {31'd0, busy}, 32'd1);
            chk("hi_hold", HI, m_hi);
            chk("lo_hold", LO, m_lo);
            if (intrude && (k == 0 || k == n - 1)) begin
                start = 1'b1;
                md_op = (k == 0) ? OP_MTLO : OP_MTHI;
                A     = (k == 0) ? intr_a : ~intr_a;
            end else begin
                start = 1'b0;
                md_op = OP_NONE;
            end
            step();
        end
        start = 1'b0;
        md_op = OP_NONE;
        m_hi  = new_hi;
        m_lo  = new_lo;
        check_outputs("done");
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        md_op  = OP_NONE;
        A      = 32'd0;
        B      = 32'd0;
        hi_sel = 1'b0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_mdout", md_out, 32'd0);
        reset = 1'b0;
        step();

        run_op(OP_MTHI, 32'h1234_5678, 32'd0, 1'b0, 32'd0);
        run_op(OP_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0, 32'd0);

        // Codes 000 and 111 must be ignored.
        start = 1'b1;
        md_op = 3'b111;
        A     = 32'hA5A5_A5A5;
        step();
        start = 1'b0;
        md_op = OP_NONE;
        check_outputs("op111");

        // Asynchronous reset between edges.
        #2 reset = 1'b1;
        #1;
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_hi", HI, 32'd0);
        chk("async_lo", LO, 32'd0);
        chk("async_mdout", md_out, 32'd0);
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        step();

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'd0);
        chk("mult_hi_const", HI, 32'hFFFF_FFFF);
        chk("mult_lo_const", LO, 32'hFFFF_FFF1);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0);
        chk("multu_hi_const", HI, 32'd1);
        chk("multu_lo_const", LO, 32'hFFFF_FFFE);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0);
        chk("div_lo_const", LO, 32'hFFFF_FFFD);
        chk("div_hi_const", HI, 32'hFFFF_FFFF);
        run_op(OP_DIVU, 32'd7, 32'd2, 1'b0, 32'd0);
        chk("divu_lo_const", LO, 32'd3);
        chk("divu_hi_const", HI, 32'd1);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0);
        chk("ovf_lo_const", LO, 32'h8000_0000);
        chk("ovf_hi_const", HI, 32'd0);

        // Busy interlock, then divide by zero.
        run_op(OP_MULT, 32'd2, 32'd3, 1'b1, 32'h55);
        chk("intlk_lo_const", LO, 32'd6);
        chk("intlk_hi_const", HI, 32'd0);
        run_op(OP_DIV, 32'd1234, 32'd0, 1'b1, 32'h77);
        chk("dz_hi_const", HI, 32'd0);
        chk("dz_lo_const", LO, 32'd6);

        // Reset in the middle of a DIVU.
        start = 1'b1;
        md_op = OP_DIVU;
        A     = 32'd100;
        B     = 32'd7;
        step();
        start = 1'b0;
        md_op = OP_NONE;
        step();
        step();
        step();
        #2 reset = 1'b1;
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_hi", HI, 32'd0);
        chk("mid_lo", LO, 32'd0);
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        for (int k = 0; k < DIV_N + 2; k++) begin
            step();
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
            chk("post_rst_lo", LO, 32'd0);
        end
        run_op(OP_MULTU, 32'd3, 32'd3, 1'b0, 32'd0);
        chk("post_rst_mul_const", LO, 32'd9);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(1, 6));
            run_op(op, rnd_word(), rnd_word(), 1'($urandom_range(0, 1)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
